// File: rtl/tap_seq_master.sv
// tap_seq_master
// On-chip JTAG sequencer. It accepts one command at a time and walks the
// target TAP controller through reset, IR scan, DR scan or Run-Test/Idle
// cycles, returning the TDO bits captured during the shift phase.
//
// Ports:
//   TCK        clock, shared with the target TAP
//   TRST       asynchronous active-high reset (also resets the target)
//   cmd_valid  command request; only looked at while cmd_ready is high
//   cmd_ready  master is idle in Run-Test/Idle and can take a command
//   cmd_type   0 = TAP reset, 1 = IR scan, 2 = DR scan, 3 = idle cycles
//   cmd_len    DR bit count (clamped to DR_MAX) or idle cycle count
//   cmd_data   scan-in data, LSB first; IR scans use [IR_LEN-1:0]
//   rsp_valid  one-cycle completion pulse, coincident with cmd_ready
//   rsp_data   captured TDO bits (bit i = i-th sample), held until the
//              next completion
//   TMS, TDI   registered drives to the target
//   TDO_in     target TDO
//
// Timing model: the state/counter registers describe the cycle currently
// on the pins. TMS/TDI/cmd_ready are registered from the *next* state so
// they change on the same edge as the state they belong to.
module tap_seq_master #(
    parameter int DR_MAX = 32,
    parameter int IR_LEN = 2,
    parameter int LEN_W  = 6
) (
    input  logic              TCK,
    input  logic              TRST,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_type,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DR_MAX-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [DR_MAX-1:0] rsp_data,
    output logic              TMS,
    output logic              TDI,
    input  logic              TDO_in
);

    localparam int IDX_W = (DR_MAX > 1) ? $clog2(DR_MAX) : 1;

    // INIT counts cycles 0..6 after reset: 0..5 drive TMS=1, 6 drives TMS=0.
    localparam logic [LEN_W-1:0] INIT_LAST = LEN_W'(6);
    // TAP-reset walk runs cycles 1..6 as counts 0..5, last one TMS=0.
    localparam logic [LEN_W-1:0] RST_LAST  = LEN_W'(5);

    typedef enum logic [2:0] {
        S_INIT,      // post-reset walk into Run-Test/Idle
        S_READY,     // parked in Run-Test/Idle
        S_RST,       // five TMS=1 then TMS=0
        S_PRE,       // Select-xR preamble up to Shift-xR
        S_SHIFT,     // one cycle per scanned bit
        S_UPD,       // Exit1 -> Update
        S_IDLE_END,  // Update -> Run-Test/Idle
        S_IDLE       // cmd_len cycles of TMS=0
    } state_t;

    state_t            state_reg, state_next;
    logic [LEN_W-1:0]  cnt_reg, cnt_next;
    logic [LEN_W-1:0]  len_reg, len_sel;
    logic              is_ir_reg, is_ir_next;
    logic [DR_MAX-1:0] data_reg;
    logic [DR_MAX-1:0] rsp_sr;
    logic [DR_MAX-1:0] rsp_data_reg;
    logic              tms_reg, tms_next;
    logic              tdi_reg, tdi_next;
    logic              ready_reg, ready_next;
    logic              valid_reg;
    logic              done_next;
    logic              accept;
    logic [LEN_W-1:0]  pre_last;

    assign cmd_ready = ready_reg;
    assign rsp_valid = valid_reg;
    assign rsp_data  = rsp_data_reg;
    assign TMS       = tms_reg;
    assign TDI       = tdi_reg;

    // IR preamble is TMS 1,1,0,0 (4 cycles), DR preamble is 1,0,0 (3 cycles).
    assign pre_last = is_ir_reg ? LEN_W'(3) : LEN_W'(2);

    // Effective scan/idle length captured at acceptance.
    always_comb begin
        len_sel = cmd_len;
        case (cmd_type)
            2'd1:    len_sel = LEN_W'(IR_LEN);
            2'd2:    len_sel = (cmd_len > LEN_W'(DR_MAX)) ? LEN_W'(DR_MAX) : cmd_len;
            default: len_sel = cmd_len;
        endcase
    end

    // State register, including the registered pin drivers.
    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            state_reg    <= S_INIT;
            cnt_reg      <= '0;
            len_reg      <= '0;
            is_ir_reg    <= 1'b0;
            data_reg     <= '0;
            tms_reg      <= 1'b1;
            tdi_reg      <= 1'b0;
            ready_reg    <= 1'b0;
            valid_reg    <= 1'b0;
            rsp_data_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            is_ir_reg <= is_ir_next;
            tms_reg   <= tms_next;
            tdi_reg   <= tdi_next;
            ready_reg <= ready_next;
            valid_reg <= done_next;
            if (accept) begin
                len_reg  <= len_sel;
                data_reg <= cmd_data;
            end
            // Only scans finish through IDLE_END; everything else reports 0.
            if (done_next) begin
                rsp_data_reg <= (state_reg == S_IDLE_END) ? rsp_sr : '0;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        is_ir_next = is_ir_reg;
        done_next  = 1'b0;
        accept     = 1'b0;
        case (state_reg)
            S_INIT: begin
                if (cnt_reg == INIT_LAST) begin
                    state_next = S_READY;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_READY: begin
                if (cmd_valid) begin
                    accept     = 1'b1;
                    cnt_next   = '0;
                    is_ir_next = (cmd_type == 2'd1);
                    case (cmd_type)
                        2'd0: state_next = S_RST;
                        2'd1: state_next = S_PRE;
                        2'd2: begin
                            // Zero-length DR scan completes without touching the TAP.
                            if (cmd_len == '0) done_next = 1'b1;
                            else               state_next = S_PRE;
                        end
                        default: begin
                            if (cmd_len == '0) done_next = 1'b1;
                            else               state_next = S_IDLE;
                        end
                    endcase
                end
            end
            S_RST: begin
                if (cnt_reg == RST_LAST) begin
                    state_next = S_READY;
                    cnt_next   = '0;
                    done_next  = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_PRE: begin
                if (cnt_reg == pre_last) begin
                    state_next = S_SHIFT;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_SHIFT: begin
                // Terminal compare on L-1 so the counter never needs to reach L.
                if (cnt_reg == len_reg - 1'b1) begin
                    state_next = S_UPD;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_UPD: begin
                state_next = S_IDLE_END;
            end
            S_IDLE_END: begin
                state_next = S_READY;
                done_next  = 1'b1;
            end
            S_IDLE: begin
                if (cnt_reg == len_reg - 1'b1) begin
                    state_next = S_READY;
                    cnt_next   = '0;
                    done_next  = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = S_INIT;
                cnt_next   = '0;
            end
        endcase
    end

    // Output logic, evaluated on the upcoming state so the pins are registered.
    always_comb begin
        tms_next   = 1'b0;
        tdi_next   = 1'b0;
        ready_next = 1'b0;
        case (state_next)
            S_INIT:  tms_next   = (cnt_next != INIT_LAST);
            S_READY: ready_next = 1'b1;
            S_RST:   tms_next   = (cnt_next != RST_LAST);
            S_PRE:   tms_next   = is_ir_next ? (cnt_next <= LEN_W'(1)) : (cnt_next == '0);
            S_SHIFT: begin
                // Last shift bit leaves Shift-xR for Exit1.
                tms_next = (cnt_next == len_reg - 1'b1);
                tdi_next = data_reg[cnt_next[IDX_W-1:0]];
            end
            S_UPD:   tms_next = 1'b1;
            default: tms_next = 1'b0;
        endcase
    end

    // TDO capture: bit gi is sampled at the end of the gi-th shift cycle.
    // The register is cleared at acceptance so short scans report zero upper bits.
    generate
        for (genvar gi = 0; gi < DR_MAX; gi++) begin : g_cap
            always_ff @(posedge TCK or posedge TRST) begin
                if (TRST) begin
                    rsp_sr[gi] <= 1'b0;
                end else if (accept) begin
                    rsp_sr[gi] <= 1'b0;
                end else if ((state_reg == S_SHIFT) && (cnt_reg == LEN_W'(gi))) begin
                    rsp_sr[gi] <= TDO_in;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_tap_seq_master.sv
// Testbench for tap_seq_master. A behavioural 2-bit-IR TAP target sits on
// TMS/TDI/TDO (bypass for IR=2, a 32-bit capture register otherwise). Each
// command's expected TMS/TDI stream, completion cycle and response are
// built from the command rules with plain queue arithmetic.
module tb_tap_seq_master;

    localparam int DR_MAX = 32;
    localparam int IR_LEN = 2;
    localparam int LEN_W  = 6;

    // Target TAP states
    localparam int TLR = 0,  RTI = 1,  SDR = 2,  CDR = 3,  SHD = 4,  E1D = 5,
                   PDR = 6,  E2D = 7,  UDR = 8,  SIR = 9,  CIR = 10, SHI = 11,
                   E1I = 12, PIR = 13, E2I = 14, UIR = 15;

    logic              TCK = 1'b0;
    logic              TRST;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_type;
    logic [LEN_W-1:0]  cmd_len;
    logic [DR_MAX-1:0] cmd_data;
    logic              rsp_valid;
    logic [DR_MAX-1:0] rsp_data;
    logic              TMS;
    logic              TDI;
    logic              TDO_in;

    int checks = 0;
    int errors = 0;

    logic [1:0]  model_ir;
    logic [31:0] prev_rsp;

    int          tap_state;
    logic [1:0]  tap_ir, tap_irsr;
    logic [31:0] tap_dr, tap_cap;
    logic        tap_byp;

    tap_seq_master #(.DR_MAX(DR_MAX), .IR_LEN(IR_LEN), .LEN_W(LEN_W)) dut (
        .TCK(TCK), .TRST(TRST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_type(cmd_type), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .TMS(TMS), .TDI(TDI), .TDO_in(TDO_in)
    );

    always #5 TCK = ~TCK;

    function automatic int tap_next(input int s, input logic m);
        case (s)
            TLR: return m ? TLR : RTI;
            RTI: return m ? SDR : RTI;
            SDR: return m ? SIR : CDR;
            CDR: return m ? E1D : SHD;
            SHD: return m ? E1D : SHD;
            E1D: return m ? UDR : PDR;
            PDR: return m ? E2D : PDR;
            E2D: return m ? UDR : SHD;
            UDR: return m ? SDR : RTI;
            SIR: return m ? TLR : CIR;
            CIR: return m ? E1I : SHI;
            SHI: return m ? E1I : SHI;
            E1I: return m ? UIR : PIR;
            PIR: return m ? E2I : PIR;
            E2I: return m ? UIR : SHI;
            default: return m ? SDR : RTI;
        endcase
    endfunction

    // Target TAP: state advances and register actions on the rising edge.
    always @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            tap_state <= TLR;
            tap_ir    <= 2'd0;
        end else begin
            tap_state <= tap_next(tap_state, TMS);
            case (tap_state)
                TLR: tap_ir <= 2'd0;
                CIR: tap_irsr <= 2'b01;
                SHI: tap_irsr <= {TDI, tap_irsr[1]};
                UIR: tap_ir <= tap_irsr;
                CDR: begin tap_byp <= 1'b0; tap_dr <= tap_cap; end
                SHD: begin tap_byp <= TDI; tap_dr <= {TDI, tap_dr[31:1]}; end
                default: ;
            endcase
        end
    end

    // Target TDO changes on the falling edge.
    always @(negedge TCK or posedge TRST) begin
        if (TRST) TDO_in <= 1'b0;
        else if (tap_state == SHI) TDO_in <= tap_irsr[0];
        else if (tap_state == SHD) TDO_in <= (tap_ir == 2'd2) ? tap_byp : tap_dr[0];
        else TDO_in <= 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Releases TRST and checks the post-reset walk into Run-Test/Idle.
    task automatic check_init(input string tag);
        TRST = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            @(posedge TCK); #1;
            chk($sformatf("%s_c%0d_valid", tag, c), rsp_valid, 0);
            chk($sformatf("%s_c%0d_tdi", tag, c), TDI, 0);
            if (c <= 6) begin
                chk($sformatf("%s_c%0d_tms", tag, c), TMS, (c <= 5) ? 1 : 0);
                chk($sformatf("%s_c%0d_ready", tag, c), cmd_ready, 0);
            end else begin
                chk($sformatf("%s_c%0d_ready", tag, c), cmd_ready, 1);
                chk($sformatf("%s_tap_rti", tag), tap_state, RTI);
                chk($sformatf("%s_rsp", tag), rsp_data, 0);
            end
        end
        model_ir = 2'd0;
        prev_rsp = 32'd0;
        $display("init %s done", tag);
    endtask

    // Issues one command and checks every cycle until completion.
    // abort_at > 0 asserts TRST in that busy cycle instead of completing.
    task automatic run_cmd(input int t, input int len, input logic [31:0] d,
                           input string tag, input int abort_at);
        int          L;
        int          n;
        int          total;
        logic [31:0] exp_rsp;
        logic [31:0] mask;
        bit          etms[$];
        bit          etdi[$];

        if (t == 1)      L = IR_LEN;
        else if (t == 2) L = (len > DR_MAX) ? DR_MAX : len;
        else             L = len;

        if (t == 0) begin
            repeat (5) etms.push_back(1'b1);
            etms.push_back(1'b0);
        end else if ((t == 1) || (t == 2 && L > 0)) begin
            etms.push_back(1'b1);
            if (t == 1) etms.push_back(1'b1);
            etms.push_back(1'b0);
            etms.push_back(1'b0);
            while (etdi.size() < etms.size()) etdi.push_back(1'b0);
            for (int i = 0; i < L; i++) begin
                etms.push_back(i == L - 1);
                etdi.push_back(d[i]);
            end
            etms.push_back(1'b1);
            etms.push_back(1'b0);
        end else if (t == 3) begin
            repeat (L) etms.push_back(1'b0);
        end
        while (etdi.size() < etms.size()) etdi.push_back(1'b0);
        total = etms.size();

        n = 0;
        while (cmd_ready !== 1'b1 && n < 200) begin
            @(posedge TCK); #1;
            n++;
        end
        chk({tag, "_ready_wait"}, cmd_ready, 1);

        tap_cap = $urandom;
        mask = (L >= 32) ? 32'hFFFF_FFFF : ((32'd1 << L) - 32'd1);
        if (t == 1)                   exp_rsp = 32'h1;
        else if (t == 2 && L > 0)     exp_rsp = (model_ir == 2'd2) ? ((d << 1) & mask) : (tap_cap & mask);
        else                          exp_rsp = 32'h0;

        cmd_valid = 1'b1;
        cmd_type  = t[1:0];
        cmd_len   = len[LEN_W-1:0];
        cmd_data  = d;
        @(posedge TCK); #1;

        for (int c = 1; c <= total + 1; c++) begin
            if (c > 1) begin
                @(posedge TCK); #1;
            end
            if (c <= total) begin
                chk($sformatf("%s_c%0d_tms", tag, c), TMS, etms[c-1]);
                chk($sformatf("%s_c%0d_tdi", tag, c), TDI, etdi[c-1]);
                chk($sformatf("%s_c%0d_ready", tag, c), cmd_ready, 0);
                chk($sformatf("%s_c%0d_valid", tag, c), rsp_valid, 0);
                chk($sformatf("%s_c%0d_hold", tag, c), rsp_data, prev_rsp);
                if (c == abort_at) begin
                    TRST = 1'b1;
                    #1;
                    chk({tag, "_abort_tms"}, TMS, 1);
                    chk({tag, "_abort_ready"}, cmd_ready, 0);
                    chk({tag, "_abort_valid"}, rsp_valid, 0);
                    chk({tag, "_abort_tdi"}, TDI, 0);
                    chk({tag, "_abort_rsp"}, rsp_data, 0);
                    cmd_valid = 1'b0;
                    $display("cmd %s type=%0d len=%0d aborted in cycle %0d", tag, t, len, c);
                    return;
                end
                // Busy-time input activity must be ignored.
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_type  = 2'($urandom);
                cmd_len   = LEN_W'($urandom);
                cmd_data  = $urandom;
            end else begin
                chk({tag, "_done_valid"}, rsp_valid, 1);
                chk({tag, "_done_ready"}, cmd_ready, 1);
                chk({tag, "_done_tms"}, TMS, 0);
                chk({tag, "_done_tdi"}, TDI, 0);
                chk({tag, "_done_rsp"}, rsp_data, exp_rsp);
                chk({tag, "_done_tap_rti"}, tap_state, RTI);
                cmd_valid = 1'b0;
            end
        end
        if (t == 1) model_ir = d[1:0];
        if (t == 0) model_ir = 2'd0;
        prev_rsp = exp_rsp;
        $display("cmd %s type=%0d len=%0d data=%h rsp=%h done cycle %0d", tag, t, len, d, rsp_data, total + 1);
    endtask

    // Idle gap with no request: pulse must have dropped, master parked.
    task automatic gap(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(posedge TCK); #1;
            chk($sformatf("gap_c%0d_valid", c), rsp_valid, 0);
            chk($sformatf("gap_c%0d_ready", c), cmd_ready, 1);
            chk($sformatf("gap_c%0d_tms", c), TMS, 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        TRST      = 1'b1;
        cmd_valid = 1'b0;
        cmd_type  = 2'd0;
        cmd_len   = '0;
        cmd_data  = '0;
        tap_cap   = 32'd0;
        model_ir  = 2'd0;
        prev_rsp  = 32'd0;
        repeat (3) @(posedge TCK);
        #1;
        chk("rst_tms", TMS, 1);
        chk("rst_tdi", TDI, 0);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_rsp", rsp_data, 0);
        check_init("init0");

        run_cmd(1, 0, 32'h2, "ir_bypass", 0);
        chk("tap_ir_bypass", tap_ir, 2);
        run_cmd(2, 8, 32'hA5, "dr_byp8", 0);
        chk("byp8_value", rsp_data, 32'h4A);
        gap(2);
        run_cmd(1, 0, 32'h0, "ir_bsr", 0);
        run_cmd(2, 40, $urandom, "dr_clamp", 0);
        run_cmd(2, 0, $urandom, "dr_zero", 0);
        run_cmd(3, 3, 32'h0, "idle3", 0);
        run_cmd(2, 1, $urandom, "dr_len1", 0);
        run_cmd(0, 0, 32'h0, "tap_reset", 0);
        run_cmd(3, 0, 32'h0, "idle0", 0);

        for (int k = 0; k < 40; k++) begin
            run_cmd($urandom_range(0, 3), $urandom_range(0, 40), $urandom,
                    $sformatf("rnd%0d", k), 0);
            if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 3));
        end

        run_cmd(2, 16, $urandom, "dr16_abort", 10);
        repeat (2) begin
            @(posedge TCK); #1;
            chk("trst_hold_tms", TMS, 1);
            chk("trst_hold_ready", cmd_ready, 0);
            chk("trst_hold_valid", rsp_valid, 0);
        end
        check_init("init1");
        run_cmd(1, 0, 32'h1, "ir_after_trst", 0);
        run_cmd(2, 32, $urandom, "dr32_after", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
